// File: rtl/exc_sequencer_pkg.sv
// exc_sequencer_pkg: shared ExcCodes, Status/Cause field positions, FSM states.
// Priority helper picks the ExcCode of the highest-priority sync trap.
package exc_sequencer_pkg;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_TR  = 5'd13;

  localparam int ST_IE   = 0;
  localparam int ST_IM   = 8;
  localparam int CA_CODE = 2;
  localparam int CA_IP   = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ENTER    = 2'd1,
    REDIRECT = 2'd2,
    RET      = 2'd3
  } state_t;

  // Falls back to Int when no sync trap is decoded.
  function automatic logic [4:0] exc_code(
    input logic sys,
    input logic brk,
    input logic teq
  );
    logic [4:0] c;
    c = EXC_INT;
    priority case (1'b1)
      sys:     c = EXC_SYS;
      brk:     c = EXC_BP;
      teq:     c = EXC_TR;
      default: c = EXC_INT;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: 2-flop synchronizer plus rising-edge detect for one irq line.
// Ports: clk, rst (async, active-high), irq (async level), rise (1-cycle pulse).
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/exc_sequencer.sv
// exc_sequencer: detects traps/interrupts/eret, sequences CP0 entry/return.
// Ports: clk, rst (async, active-high), instr_valid, pc_i, syscall_i,
//   break_i, teq_trap_i, eret_i, irq_i, status_i, epc_i -> stall_o, kill_o,
//   exc_o, eret_o, cause_o, epc_o, redirect_o, redirect_pc_o.
// Build option: EXC_VECTORED_EN gives one vector per ExcCode.
module exc_sequencer
  import exc_sequencer_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0020,
  parameter int          NUM_INT    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [31:0]        pc_i,
  input  logic               syscall_i,
  input  logic               break_i,
  input  logic               teq_trap_i,
  input  logic               eret_i,
  input  logic [NUM_INT-1:0] irq_i,
  input  logic [31:0]        status_i,
  input  logic [31:0]        epc_i,
  output logic               stall_o,
  output logic               kill_o,
  output logic               exc_o,
  output logic               eret_o,
  output logic [31:0]        cause_o,
  output logic [31:0]        epc_o,
  output logic               redirect_o,
  output logic [31:0]        redirect_pc_o
);

  state_t state_q;
  state_t state_d;

  logic [NUM_INT-1:0] rise;
  logic [NUM_INT-1:0] pend_q;
  logic [NUM_INT-1:0] req;
  logic [NUM_INT-1:0] take;

  logic [31:0] cause_q;
  logic [31:0] epc_q;
  logic [31:0] rpc_q;
  logic [31:0] cause_d;
  logic [31:0] target;
  logic [4:0]  code;

  logic idle;
  logic sync_trap;
  logic int_ok;
  logic exc_trig;
  logic eret_trig;
  logic unused_ok;

  for (genvar g = 0; g < NUM_INT; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .irq  (irq_i[g]),
      .rise (rise[g])
    );
  end

  assign idle      = (state_q == IDLE);
  assign req       = pend_q & status_i[ST_IM +: NUM_INT];
  assign int_ok    = status_i[ST_IE] & (|req);
  assign sync_trap = syscall_i | break_i | teq_trap_i;

  assign exc_trig  = ~rst & idle & instr_valid
                   & (sync_trap | int_ok);
  assign eret_trig = ~rst & idle & instr_valid
                   & eret_i & ~(sync_trap | int_ok);

  // Only a taken interrupt consumes pending: lowest set line.
  assign take = (exc_trig & ~sync_trap) ? (req & (-req)) : '0;
  assign code = exc_code(syscall_i, break_i, teq_trap_i);

  always_comb begin
    cause_d = '0;
    cause_d[CA_CODE +: 5]     = code;
    cause_d[CA_IP +: NUM_INT] = pend_q;
  end

`ifdef EXC_VECTORED_EN
  assign target = EXC_VECTOR + 32'(code) * VEC_STRIDE;
`else
  assign target = EXC_VECTOR;
`endif

  assign unused_ok = ^{status_i, VEC_STRIDE};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    exc_o         = 1'b0;
    eret_o        = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = rpc_q;
    unique case (state_q)
      IDLE: begin
        if (exc_trig)       state_d = ENTER;
        else if (eret_trig) state_d = RET;
      end
      ENTER: begin
        exc_o   = 1'b1;
        state_d = REDIRECT;
      end
      REDIRECT: begin
        redirect_o = 1'b1;
        state_d    = IDLE;
      end
      RET: begin
        eret_o        = 1'b1;
        redirect_o    = 1'b1;
        redirect_pc_o = epc_i;
        state_d       = IDLE;
      end
    endcase
  end

  // Edges that land on the take cycle survive the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      cause_q <= '0;
      epc_q   <= '0;
      rpc_q   <= '0;
    end else begin
      pend_q <= (pend_q & ~take) | rise;
      if (exc_trig) begin
        cause_q <= cause_d;
        epc_q   <= sync_trap ? pc_i + 32'd4 : pc_i;
        rpc_q   <= target;
      end else if (state_q == RET) begin
        rpc_q <= epc_i;
      end
    end
  end

  assign stall_o = exc_trig | eret_trig | ~idle;
  assign kill_o  = exc_trig;
  assign cause_o = cause_q;
  assign epc_o   = epc_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// tb_exc_sequencer: vector table, hand sequences and random run
// checked against a queue-based behavioural model.
module tb_exc_sequencer;

  localparam int          N   = 6;
  localparam logic [31:0] VEC = 32'h0040_0004;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic [31:0]   pc;
  logic          syscall;
  logic          brk;
  logic          teq;
  logic          eret;
  logic [N-1:0]  irq;
  logic [31:0]   status;
  logic [31:0]   epc_in;
  logic          stall;
  logic          kill;
  logic          exc;
  logic          eret_s;
  logic [31:0]   cause;
  logic [31:0]   epc;
  logic          redirect;
  logic [31:0]   rpc;

  exc_sequencer #(
    .EXC_VECTOR (VEC),
    .VEC_STRIDE (32'h20),
    .NUM_INT    (N)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .pc_i          (pc),
    .syscall_i     (syscall),
    .break_i       (brk),
    .teq_trap_i    (teq),
    .eret_i        (eret),
    .irq_i         (irq),
    .status_i      (status),
    .epc_i         (epc_in),
    .stall_o       (stall),
    .kill_o        (kill),
    .exc_o         (exc),
    .eret_o        (eret_s),
    .cause_o       (cause),
    .epc_o         (epc),
    .redirect_o    (redirect),
    .redirect_pc_o (rpc)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tgt(input int code);
`ifdef EXC_VECTORED_EN
    return VEC + 32'(code) * 32'h20;
`else
    return VEC + 32'(code) * 32'h0;
`endif
  endfunction

  // Model: upcoming non-idle cycles kept as a queue of cycle kinds.
  typedef enum int {K_EXC, K_RED, K_RET} kind_t;
  kind_t        mq[$];
  logic [N-1:0] m_pend;
  logic [N-1:0] m_h0, m_h1, m_h2;
  logic [31:0]  m_cause, m_epc, m_rpc;

  logic        s_stall, s_kill, s_exc, s_eret, s_red;
  logic [31:0] s_cause, s_epc, s_rpc;

  task automatic model_reset();
    mq.delete();
    m_pend = '0;
    m_h0 = '0; m_h1 = '0; m_h2 = '0;
    m_cause = '0; m_epc = '0; m_rpc = '0;
  endtask

  task automatic model_trig(output bit t_exc, output bit t_eret,
                            output int code, output int line);
    logic [N-1:0] rq;
    rq = m_pend & status[8 +: N];
    line = -1;
    for (int i = N - 1; i >= 0; i--) if (rq[i]) line = i;
    t_exc = 0;
    t_eret = 0;
    code = 0;
    if (rst || mq.size() != 0 || !instr_valid) return;
    if (syscall)                       code = 8;
    else if (brk)                      code = 9;
    else if (teq)                      code = 13;
    else if (status[0] && line >= 0)   code = 0;
    else begin
      t_eret = eret;
      return;
    end
    t_exc = 1;
  endtask

  task automatic tick();
    bit te, tr, busy;
    int code, line;
    kind_t k;
    logic [N-1:0] rise;
    logic [31:0] e_rpc;
    #2;
    model_trig(te, tr, code, line);
    busy = !rst && mq.size() != 0;
    k = busy ? mq[0] : K_EXC;
    e_rpc = (busy && k == K_RET) ? epc_in : m_rpc;
    s_stall = stall; s_kill = kill; s_exc = exc; s_eret = eret_s;
    s_red = redirect; s_cause = cause; s_epc = epc; s_rpc = rpc;
    chk("m_stall", stall, busy | te | tr);
    chk("m_kill", kill, te);
    chk("m_exc", exc, busy && k == K_EXC);
    chk("m_eret", eret_s, busy && k == K_RET);
    chk("m_redirect", redirect, busy && k != K_EXC);
    chk("m_cause", cause, rst ? 32'h0 : m_cause);
    chk("m_epc", epc, rst ? 32'h0 : m_epc);
    chk("m_rpc", rpc, rst ? 32'h0 : e_rpc);
    @(posedge clk);
    if (rst) model_reset();
    else begin
      rise = m_h1 & ~m_h2;
      if (busy) begin
        if (k == K_RET) m_rpc = epc_in;
        void'(mq.pop_front());
      end else if (te) begin
        m_cause = '0;
        m_cause[6:2] = code[4:0];
        m_cause[10 +: N] = m_pend;
        m_epc = (code == 0) ? pc : pc + 32'd4;
        m_rpc = tgt(code);
        if (code == 0) m_pend[line] = 1'b0;
        mq.push_back(K_EXC);
        mq.push_back(K_RED);
      end else if (tr) begin
        mq.push_back(K_RET);
      end
      m_pend = m_pend | rise;
      m_h2 = m_h1; m_h1 = m_h0; m_h0 = irq;
    end
    @(negedge clk);
  endtask

  task automatic run_until_exc(input int max, output bit seen);
    seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      seen = s_exc;
    end
  endtask

  task automatic idle_inputs();
    instr_valid = 0; syscall = 0; brk = 0; teq = 0; eret = 0;
  endtask

  typedef struct {
    bit          sys, brk, teq, ert;
    logic [31:0] pc, epci;
    bit          e_kill;
    int          e_code;
    logic [31:0] e_epc, e_rpc;
  } vec_t;

  vec_t tv[7];
  bit   seen;
  bit   any;

  initial begin
    model_reset();
    rst = 1; idle_inputs(); pc = 0; irq = '0; status = 0; epc_in = 0;
    tv[0] = '{1, 0, 0, 0, 32'h0040_0100, 0, 1, 8,
              32'h0040_0104, tgt(8)};
    tv[1] = '{0, 1, 0, 0, 32'h0040_0300, 0, 1, 9,
              32'h0040_0304, tgt(9)};
    tv[2] = '{0, 0, 1, 0, 32'hFFFF_FFFC, 0, 1, 13,
              32'h0000_0000, tgt(13)};
    tv[3] = '{1, 0, 1, 0, 32'h0040_0400, 0, 1, 8,
              32'h0040_0404, tgt(8)};
    tv[4] = '{0, 1, 1, 0, 32'h0040_0410, 0, 1, 9,
              32'h0040_0414, tgt(9)};
    tv[5] = '{0, 0, 0, 1, 32'h0040_0420, 32'h0040_0104, 0, -1,
              0, 32'h0040_0104};
    tv[6] = '{1, 0, 0, 1, 32'h0040_0430, 32'h1234_5678, 1, 8,
              32'h0040_0434, tgt(8)};

    // Reset holds everything low even with a trap presented.
    instr_valid = 1; syscall = 1;
    tick();
    chk("rst_stall", s_stall, 0);
    chk("rst_kill", s_kill, 0);
    tick();
    chk("rst_rpc", s_rpc, 0);
    rst = 0; idle_inputs();
    tick();
    chk("rst_idle_stall", s_stall, 0);

    for (int v = 0; v < 7; v++) begin
      instr_valid = 1; pc = tv[v].pc; epc_in = tv[v].epci;
      syscall = tv[v].sys; brk = tv[v].brk;
      teq = tv[v].teq; eret = tv[v].ert;
      tick();
      chk($sformatf("v%0d_kill", v), s_kill, tv[v].e_kill);
      chk($sformatf("v%0d_stall", v), s_stall, 1);
      if (tv[v].e_code >= 0) begin
        tick();
        chk($sformatf("v%0d_exc", v), s_exc, 1);
        chk($sformatf("v%0d_code", v), s_cause[6:2], tv[v].e_code);
        chk($sformatf("v%0d_epc", v), s_epc, tv[v].e_epc);
        tick();
        chk($sformatf("v%0d_redir", v), s_red, 1);
        chk($sformatf("v%0d_rpc", v), s_rpc, tv[v].e_rpc);
      end else begin
        tick();
        chk($sformatf("v%0d_eret", v), s_eret, 1);
        chk($sformatf("v%0d_redir", v), s_red, 1);
        chk($sformatf("v%0d_rpc", v), s_rpc, tv[v].e_rpc);
      end
      idle_inputs();
      tick();
      chk($sformatf("v%0d_done", v), s_stall, 0);
    end

    // irq[2] with IE=1, IM[2]=1.
    status = 32'h0000_0401; pc = 32'h0040_0200; instr_valid = 1;
    irq[2] = 1;
    run_until_exc(10, seen);
    chk("irq2_seen", seen, 1);
    chk("irq2_code", s_cause[6:2], 0);
    chk("irq2_ip", s_cause[12], 1);
    chk("irq2_epc", s_epc, 32'h0040_0200);
    status = 32'h0000_0400;
    tick();
    status = 32'h0000_0401;
    any = 0;
    for (int i = 0; i < 6; i++) begin tick(); any |= s_exc; end
    chk("irq2_cleared", any, 0);

    // irq[1] waits while IE=0, then is taken.
    status = 32'h0000_0200; pc = 32'h0040_0300; irq[1] = 1;
    any = 0;
    for (int i = 0; i < 8; i++) begin tick(); any |= s_exc; end
    chk("irq1_blocked", any, 0);
    status = 32'h0000_0201; pc = 32'h0040_0500;
    tick();
    chk("irq1_kill", s_kill, 1);
    tick();
    chk("irq1_exc", s_exc, 1);
    chk("irq1_epc", s_epc, 32'h0040_0500);
    chk("irq1_ip", s_cause[11], 1);
    tick();
    idle_inputs(); irq = '0; status = 0;
    for (int i = 0; i < 4; i++) tick();

    // syscall+teq with an irq edge arriving while busy.
    status = 32'h0000_0801; pc = 32'h0040_0600;
    instr_valid = 1; syscall = 1; teq = 1; irq[3] = 1;
    tick();
    chk("mix_kill", s_kill, 1);
    tick();
    chk("mix_code", s_cause[6:2], 8);
    tick();
    syscall = 0; teq = 0; pc = 32'h0040_0700;
    run_until_exc(8, seen);
    chk("mix_irq_seen", seen, 1);
    chk("mix_irq_code", s_cause[6:2], 0);
    chk("mix_irq_epc", s_epc, 32'h0040_0700);
    tick();
    idle_inputs(); irq = '0; status = 0;
    for (int i = 0; i < 4; i++) tick();

    // Reset during ENTER.
    instr_valid = 1; syscall = 1; pc = 32'h0040_0800;
    tick();
    chk("rse_kill", s_kill, 1);
    rst = 1;
    tick();
    chk("rse_exc", s_exc, 0);
    rst = 0; idle_inputs();
    tick();
    chk("rse_stall", s_stall, 0);
    chk("rse_exc2", s_exc, 0);
    tick();
    chk("rse_redir", s_red, 0);

    for (int c = 0; c < 500; c++) begin
      instr_valid = $urandom_range(0, 3) != 0;
      syscall = $urandom_range(0, 15) == 0;
      brk     = $urandom_range(0, 15) == 0;
      teq     = $urandom_range(0, 15) == 0;
      eret    = $urandom_range(0, 7) == 0;
      pc      = $urandom() & 32'hFFFF_FFFC;
      epc_in  = $urandom();
      if ($urandom_range(0, 3) == 0) irq = N'($urandom());
      status    = $urandom();
      status[0] = $urandom_range(0, 3) != 0;
      rst       = $urandom_range(0, 99) == 0;
      tick();
    end
    rst = 0; idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
